// File: rtl/hazard_tag_pipeline_if.sv
// hazard_tag_pipeline_if: ID-stage tag inputs, stage tags and stall status
// exchanged between the hazard tag pipeline and its surroundings.
interface hazard_tag_pipeline_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              idValid;
    logic [REG_AW-1:0] idRd;
    logic              idRegWrite;
    logic              idMemRead;
    logic [REG_AW-1:0] idRs1;
    logic [REG_AW-1:0] idRs2;
    logic              idUseRs1;
    logic              idUseRs2;
    logic              flush;
    logic              freeze;
    logic              stall;
    logic [REG_AW-1:0] rdEx;
    logic              regWriteEx;
    logic              memReadEx;
    logic [REG_AW-1:0] rdMem;
    logic              regWriteMem;
    logic [REG_AW-1:0] rdWb;
    logic              regWriteWb;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output idValid, idRd, idRegWrite, idMemRead, idRs1, idRs2, idUseRs1, idUseRs2, flush, freeze,
        input  stall, rdEx, regWriteEx, memReadEx, rdMem, regWriteMem, rdWb, regWriteWb, stallCount
    );

    modport slave (
        input  idValid, idRd, idRegWrite, idMemRead, idRs1, idRs2, idUseRs1, idUseRs2, flush, freeze,
        output stall, rdEx, regWriteEx, memReadEx, rdMem, regWriteMem, rdWb, regWriteWb, stallCount
    );
endinterface

// File: rtl/hazard_tag_pipeline.sv
// hazard_tag_pipeline: carries destination tags through EX/MEM/WB for the
// forwarding unit, inserts a bubble on load-use hazards and counts stall cycles.
module hazard_tag_pipeline #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic                  clk,
    input logic                  reset,
    hazard_tag_pipeline_if.slave bus
);
    logic              loadUse;
    logic              killId;
    logic [REG_AW-1:0] exRdNext;
    logic              exRegWriteNext;
    logic              exMemReadNext;
    logic [CNT_W-1:0]  cntNext;

    always_comb begin
        loadUse = bus.idValid & bus.memReadEx & bus.regWriteEx &
                  ((bus.idUseRs1 & (bus.idRs1 == bus.rdEx)) | (bus.idUseRs2 & (bus.idRs2 == bus.rdEx)));
        killId = bus.flush | loadUse | ~bus.idValid;
        exRdNext = killId ? '0 : bus.idRd;
        // writes to x0 are dropped here so the forwarding unit never matches x0
        exRegWriteNext = ~killId & bus.idRegWrite & (bus.idRd != '0);
        exMemReadNext = ~killId & bus.idMemRead;
        cntNext = &bus.stallCount ? bus.stallCount : bus.stallCount + 1'b1;
    end

    assign bus.stall = ~reset & (bus.freeze | (loadUse & ~bus.flush));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdEx <= '0;
            bus.regWriteEx <= 1'b0;
            bus.memReadEx <= 1'b0;
            bus.rdMem <= '0;
            bus.regWriteMem <= 1'b0;
            bus.rdWb <= '0;
            bus.regWriteWb <= 1'b0;
            bus.stallCount <= '0;
        end else begin
            if (!bus.freeze) begin
                bus.rdWb <= bus.rdMem;
                bus.regWriteWb <= bus.regWriteMem;
                bus.rdMem <= bus.rdEx;
                bus.regWriteMem <= bus.regWriteEx;
                bus.rdEx <= exRdNext;
                bus.regWriteEx <= exRegWriteNext;
                bus.memReadEx <= exMemReadNext;
            end
            if (bus.stall) bus.stallCount <= cntNext;
        end
    end
endmodule

// File: tb/tb_hazard_tag_pipeline.sv
// tb_hazard_tag_pipeline: directed scenarios plus randomized traffic checked
// against a stage-list reference model of the tag pipeline.
module tb_hazard_tag_pipeline;
    localparam int AW = 5;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } tag_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    tag_t mEx, mMem, mWb;
    int   mCnt;

    hazard_tag_pipeline_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    hazard_tag_pipeline #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic mLoadUse();
        return bus.idValid && mEx.mr && mEx.rw &&
               ((bus.idUseRs1 && bus.idRs1 == mEx.rd) || (bus.idUseRs2 && bus.idRs2 == mEx.rd));
    endfunction

    function automatic logic mStall();
        return bus.freeze || (mLoadUse() && !bus.flush);
    endfunction

    task automatic modelClear();
        mEx = '0; mMem = '0; mWb = '0; mCnt = 0;
    endtask

    task automatic setId(input logic v, input int rd, input logic rw, input logic mr,
                         input int rs1, input int rs2, input logic u1, input logic u2);
        bus.idValid = v; bus.idRd = AW'(rd); bus.idRegWrite = rw; bus.idMemRead = mr;
        bus.idRs1 = AW'(rs1); bus.idRs2 = AW'(rs2); bus.idUseRs1 = u1; bus.idUseRs2 = u2;
    endtask

    task automatic step();
        tag_t nEx;
        logic st, fz;
        st = mStall();
        fz = bus.freeze;
        nEx = (bus.flush || mLoadUse() || !bus.idValid) ? tag_t'(0)
              : '{rd: bus.idRd, rw: bus.idRegWrite && bus.idRd != 0, mr: bus.idMemRead};
        @(posedge clk);
        #1;
        if (!fz) begin
            mWb = mMem; mMem = mEx; mEx = nEx;
        end
        if (st && mCnt < CMAX) mCnt++;
    endtask

    task automatic test_reset();
        setId(1, 3, 1, 0, 1, 2, 1, 1); step();
        setId(1, 4, 1, 0, 3, 2, 1, 1); step();
        bus.freeze = 1'b1; step(); bus.freeze = 1'b0;
        setId(1, 6, 1, 0, 4, 3, 1, 1); step();
        total++; if (bus.rdWb !== mWb.rd) begin bad++; $display("FAIL prereset_rdWb got=%0d exp=%0d", bus.rdWb, mWb.rd); end
        total++; if (bus.stallCount !== CW'(mCnt)) begin bad++; $display("FAIL prereset_cnt got=%0d exp=%0d", bus.stallCount, mCnt); end
        #2;
        bus.freeze = 1'b1;
        reset = 1'b1;
        #1;
        total++; if ({bus.rdEx, bus.rdMem, bus.rdWb} !== '0) begin bad++; $display("FAIL reset_tags got=%0h exp=0", {bus.rdEx, bus.rdMem, bus.rdWb}); end
        total++; if ({bus.regWriteEx, bus.memReadEx, bus.regWriteMem, bus.regWriteWb} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.regWriteEx, bus.memReadEx, bus.regWriteMem, bus.regWriteWb}); end
        total++; if (bus.stallCount !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.stallCount); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        @(posedge clk); #1;
        reset = 1'b0; bus.freeze = 1'b0;
        modelClear();
    endtask

    task automatic test_alu_forward();
        setId(1, 5, 1, 0, 1, 2, 1, 1); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL alu_stall0 got=%b exp=0", bus.stall); end
        step();
        setId(1, 9, 1, 0, 5, 5, 1, 1); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL alu_stall1 got=%b exp=0", bus.stall); end
        step();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.rdMem !== 5'd5 || bus.regWriteMem !== 1'b1) begin bad++; $display("FAIL alu_mem got=%0d/%b exp=5/1", bus.rdMem, bus.regWriteMem); end
        total++; if (bus.rdEx !== 5'd9) begin bad++; $display("FAIL alu_ex got=%0d exp=9", bus.rdEx); end
        step();
    endtask

    task automatic test_load_use();
        int c0;
        setId(1, 7, 1, 1, 2, 3, 1, 1); step();
        c0 = mCnt;
        setId(1, 8, 1, 0, 7, 1, 1, 1); #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
        step();
        total++; if (bus.rdEx !== 0 || bus.regWriteEx !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0d/%b exp=0/0", bus.rdEx, bus.regWriteEx); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", bus.stall); end
        step();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.rdEx !== 5'd8) begin bad++; $display("FAIL lu_add_ex got=%0d exp=8", bus.rdEx); end
        total++; if (bus.rdWb !== 5'd7 || bus.regWriteWb !== 1'b1) begin bad++; $display("FAIL lu_wb got=%0d/%b exp=7/1", bus.rdWb, bus.regWriteWb); end
        total++; if (bus.stallCount !== CW'(c0 + 1)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.stallCount, c0 + 1); end
        step();
    endtask

    task automatic test_no_hazard();
        setId(1, 7, 1, 1, 2, 3, 1, 1); step();
        setId(1, 8, 1, 0, 7, 1, 0, 1); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nh_unused got=%b exp=0", bus.stall); end
        step();
        setId(1, 7, 1, 1, 2, 3, 1, 1); step();
        setId(1, 8, 1, 0, 0, 1, 1, 1); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nh_other got=%b exp=0", bus.stall); end
        step();
        setId(1, 0, 1, 1, 2, 3, 1, 1); step();
        setId(1, 8, 1, 0, 0, 0, 1, 1); #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nh_x0 got=%b exp=0", bus.stall); end
        step();
        setId(0, 0, 0, 0, 0, 0, 0, 0); step();
    endtask

    task automatic test_flush_load_use();
        int c0;
        setId(1, 7, 1, 1, 2, 3, 1, 1); step();
        c0 = mCnt;
        setId(1, 8, 1, 0, 1, 7, 0, 1); bus.flush = 1'b1; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b exp=0", bus.stall); end
        step();
        bus.flush = 1'b0; setId(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.rdEx !== 0 || bus.regWriteEx !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%0d/%b exp=0/0", bus.rdEx, bus.regWriteEx); end
        total++; if (bus.stallCount !== CW'(c0)) begin bad++; $display("FAIL fl_cnt got=%0d exp=%0d", bus.stallCount, c0); end
        step();
    endtask

    task automatic test_freeze();
        int c0;
        logic [3*AW-1:0] held;
        setId(1, 3, 1, 0, 1, 1, 1, 1); step();
        setId(1, 4, 1, 0, 1, 1, 1, 1); step();
        setId(1, 6, 1, 0, 1, 1, 1, 1); step();
        setId(1, 10, 1, 0, 1, 1, 1, 1);
        held = {bus.rdEx, bus.rdMem, bus.rdWb};
        c0 = mCnt;
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fz_stall%0d got=%b exp=1", i, bus.stall); end
            step();
            total++; if ({bus.rdEx, bus.rdMem, bus.rdWb} !== {mEx.rd, mMem.rd, mWb.rd} || {bus.rdEx, bus.rdMem, bus.rdWb} !== held) begin bad++; $display("FAIL fz_hold%0d got=%0h exp=%0h", i, {bus.rdEx, bus.rdMem, bus.rdWb}, held); end
        end
        bus.freeze = 1'b0;
        total++; if (bus.stallCount !== CW'(c0 + 3)) begin bad++; $display("FAIL fz_cnt got=%0d exp=%0d", bus.stallCount, c0 + 3); end
        step();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if ({bus.rdEx, bus.rdMem, bus.rdWb} !== {5'd10, 5'd6, 5'd4}) begin bad++; $display("FAIL fz_resume got=%0h exp=%0h", {bus.rdEx, bus.rdMem, bus.rdWb}, {5'd10, 5'd6, 5'd4}); end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            setId($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            bus.flush = $urandom_range(0, 9) == 0;
            bus.freeze = $urandom_range(0, 9) == 0;
            #1;
            total++; if (bus.stall !== mStall()) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, bus.stall, mStall()); end
            step();
            total++; if ({bus.rdEx, bus.regWriteEx, bus.memReadEx, bus.rdMem, bus.regWriteMem, bus.rdWb, bus.regWriteWb} !==
                        {mEx.rd, mEx.rw, mEx.mr, mMem.rd, mMem.rw, mWb.rd, mWb.rw}) begin
                bad++; $display("FAIL rnd_tags cyc=%0d got=%0h exp=%0h", i,
                    {bus.rdEx, bus.regWriteEx, bus.memReadEx, bus.rdMem, bus.regWriteMem, bus.rdWb, bus.regWriteWb},
                    {mEx.rd, mEx.rw, mEx.mr, mMem.rd, mMem.rw, mWb.rd, mWb.rw});
            end
            total++; if (bus.stallCount !== CW'(mCnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, bus.stallCount, mCnt); end
        end
        bus.flush = 1'b0; bus.freeze = 1'b0;
    endtask

    task automatic test_saturate();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        bus.freeze = 1'b1;
        for (int i = 0; i < CMAX + 5; i++) step();
        total++; if (bus.stallCount !== CW'(CMAX)) begin bad++; $display("FAIL sat_max got=%0d exp=%0d", bus.stallCount, CMAX); end
        step();
        total++; if (bus.stallCount !== CW'(CMAX)) begin bad++; $display("FAIL sat_hold got=%0d exp=%0d", bus.stallCount, CMAX); end
        bus.freeze = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0; bus.freeze = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        modelClear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_no_hazard();
        test_flush_load_use();
        test_freeze();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
